// File: rtl/mips150_lsu.sv
// MIPS150 load/store unit: region decode, big-endian byte-lane enables, next-cycle load
// alignment/extension, and a stalling valid/ready IO port with a bounded wait.
module mips150_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = 12,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [DATA_W/8-1:0] dmem_we,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W/8-1:0] imem_we,
  output logic [MEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              io_valid,
  input  logic              io_ready,
  output logic [DATA_W/8-1:0] io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic              err_misalign,
  output logic              err_timeout
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic {IDLE, IO_WAIT} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_DMEM, SRC_IO, SRC_ONES} src_t;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              resp_vld_q, resp_vld_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic [OB-1:0]     ld_off_q, ld_off_d;
  logic              ld_uns_q, ld_uns_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              io_load_q, io_load_d;
  logic [NB-1:0]     io_we_q, io_we_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

  logic [3:0]        region;
  logic [OB-1:0]     off;
  logic [3:0]        nbytes;
  logic              misalign, accept, to_mem;
  logic [NB-1:0]     lanes;
  logic [DATA_W-1:0] wrep;

  // Right-justify the big-endian field at byte offset off, then sign- or zero-extend.
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] raw, input logic [1:0] size,
                                               input logic [OB-1:0] offs, input logic uns);
    int nb, sft;
    logic [DATA_W-1:0] up;
    nb  = ((1 << size) > NB) ? NB : (1 << size);
    sft = DATA_W - 8 * nb;
    up  = (raw >> (DATA_W - 8 * (int'(offs) + nb))) << sft;
    align = uns ? (up >> sft) : $unsigned($signed(up) >>> sft);
  endfunction

  always_comb begin
    region   = req_addr[ADDR_W-1 -: 4];
    off      = req_addr[OB-1:0];
    nbytes   = 4'd1 << req_size;
    misalign = (nbytes > 4'(NB)) || ((4'(off) & (nbytes - 4'd1)) != 4'd0);
    to_mem   = (region == 4'h1) || (region == 4'h3);
    lanes    = '0;
    for (int i = 0; i < NB; i++) begin
      lanes[NB-1-i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
    end
    case (req_size)
      2'd0:    wrep = {NB{req_wdata[7:0]}};
      2'd1:    wrep = {(NB/2){req_wdata[15:0]}};
      2'd2:    wrep = {(NB/4){req_wdata[31:0]}};
      default: wrep = req_wdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    resp_vld_d = 1'b0;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    ld_size_d  = ld_size_q;
    ld_off_d   = ld_off_q;
    ld_uns_d   = ld_uns_q;
    ld_rd_d    = ld_rd_q;
    io_load_d  = io_load_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_rdata_d = io_rdata_q;
    dmem_we    = '0;
    imem_we    = '0;
    req_ready  = (state_q == IDLE) && !rst;
    accept     = req_valid && req_ready;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (misalign) begin
            err_mis_d = 1'b1;
          end else if (region == 4'h8) begin
            state_d    = IO_WAIT;
            io_load_d  = !req_store;
            io_we_d    = req_store ? lanes : '0;
            io_addr_d  = req_addr;
            io_wdata_d = wrep;
          end else if (req_store) begin
            if (to_mem) dmem_we = lanes;
            if (region == 4'h2 || region == 4'h3) imem_we = lanes;
          end else begin
            resp_vld_d = 1'b1;
            src_d      = to_mem ? SRC_DMEM : SRC_ZERO;
          end
          // Load context is shared by DMEM and IO loads; only one can be outstanding.
          if (!misalign && !req_store) begin
            ld_size_d = req_size;
            ld_off_d  = off;
            ld_uns_d  = req_unsigned;
            ld_rd_d   = req_rd;
          end
        end
      end
      IO_WAIT: begin
        if (io_ready) begin
          state_d = IDLE;
          if (io_load_q) begin
            resp_vld_d = 1'b1;
            src_d      = SRC_IO;
            io_rdata_d = io_rdata;
          end
        end else if (cnt_q == 10'(IO_TIMEOUT - 1)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
          if (io_load_q) begin
            resp_vld_d = 1'b1;
            src_d      = SRC_ONES;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= SRC_ZERO;
      cnt_q      <= '0;
      resp_vld_q <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
      ld_size_q  <= '0;
      ld_off_q   <= '0;
      ld_uns_q   <= 1'b0;
      ld_rd_q    <= '0;
      io_load_q  <= 1'b0;
      io_we_q    <= '0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      resp_vld_q <= resp_vld_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
      ld_size_q  <= ld_size_d;
      ld_off_q   <= ld_off_d;
      ld_uns_q   <= ld_uns_d;
      ld_rd_q    <= ld_rd_d;
      io_load_q  <= io_load_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  always_comb begin
    resp_data = '0;
    if (resp_vld_q) begin
      case (src_q)
        SRC_DMEM: resp_data = align(dmem_rdata, ld_size_q, ld_off_q, ld_uns_q);
        SRC_IO:   resp_data = align(io_rdata_q, ld_size_q, ld_off_q, ld_uns_q);
        SRC_ONES: resp_data = '1;
        default:  resp_data = '0;
      endcase
    end
  end

  assign dmem_addr    = req_addr[OB+MEM_AW-1:OB];
  assign imem_addr    = req_addr[OB+MEM_AW-1:OB];
  assign dmem_wdata   = wrep;
  assign imem_wdata   = wrep;
  assign io_valid     = (state_q == IO_WAIT);
  assign io_we        = io_we_q;
  assign io_addr      = io_addr_q;
  assign io_wdata     = io_wdata_q;
  assign resp_valid   = resp_vld_q;
  assign resp_rd      = resp_vld_q ? ld_rd_q : 5'd0;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;
endmodule

// File: tb/tb_mips150_lsu.sv
// Bench for mips150_lsu: a 32-bit instance (IO_TIMEOUT=8) and a 64-bit instance, directed
// vectors plus randomized DMEM/IMEM traffic checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_mips150_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd, resp_rd;
  logic [3:0]  dmem_we, imem_we, io_we;
  logic [11:0] dmem_addr, imem_addr;
  logic [31:0] dmem_wdata, imem_wdata, dmem_rdata, io_addr, io_wdata, io_rdata, resp_data;
  logic        io_valid, io_ready, resp_valid, err_misalign, err_timeout;

  logic        w_req_valid, w_req_ready, w_req_store, w_req_unsigned;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr, w_io_addr;
  logic [63:0] w_req_wdata, w_dmem_wdata, w_imem_wdata, w_dmem_rdata, w_io_wdata, w_io_rdata, w_resp_data;
  logic [4:0]  w_req_rd, w_resp_rd;
  logic [7:0]  w_dmem_we, w_imem_we, w_io_we;
  logic [11:0] w_dmem_addr, w_imem_addr;
  logic        w_io_valid, w_io_ready, w_resp_valid, w_err_misalign, w_err_timeout;

  mips150_lsu #(.DATA_W(32), .ADDR_W(32), .MEM_AW(12), .IO_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .io_valid(io_valid), .io_ready(io_ready), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout));

  mips150_lsu #(.DATA_W(64), .ADDR_W(32), .MEM_AW(12), .IO_TIMEOUT(255)) dut64 (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
    .req_size(w_req_size), .req_unsigned(w_req_unsigned), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .req_rd(w_req_rd), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
    .dmem_rdata(w_dmem_rdata), .imem_we(w_imem_we), .imem_addr(w_imem_addr), .imem_wdata(w_imem_wdata),
    .io_valid(w_io_valid), .io_ready(w_io_ready), .io_we(w_io_we), .io_addr(w_io_addr), .io_wdata(w_io_wdata),
    .io_rdata(w_io_rdata), .resp_valid(w_resp_valid), .resp_rd(w_resp_rd), .resp_data(w_resp_data),
    .err_misalign(w_err_misalign), .err_timeout(w_err_timeout));

  // Reference model for the 32-bit bus, expressed as byte offsets counted from the MSB.
  function automatic bit m_misalign(input int sz, input int off);
    int n = 1 << sz;
    return (n > 4) || ((off % n) != 0);
  endfunction

  function automatic logic [3:0] m_lanes(input int sz, input int off);
    logic [3:0] r = '0;
    int n = 1 << sz;
    for (int k = 0; k < 4; k++) if (k >= off && k < off + n) r[3-k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    longint unsigned v, r;
    int n = 1 << sz;
    v = longint'(d) % (64'd1 << (8 * n));
    r = 0;
    for (int j = 0; j < 4 / n; j++) r = (r << (8 * n)) | v;
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int sz, input int off, input bit uns);
    longint unsigned v = 0;
    int n = 1 << sz;
    for (int k = 0; k < n; k++) v = v * 256 + longint'((rd >> (8 * (3 - off - k))) & 32'hFF);
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic drive_req(input bit vld, input bit st, input int sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    req_valid = vld; req_store = st; req_size = 2'(sz); req_unsigned = uns;
    req_addr = a; req_wdata = d; req_rd = rd;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      checks++; if ({io_valid, resp_valid, err_misalign, err_timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {io_valid, resp_valid, err_misalign, err_timeout}); end
      checks++; if ({dmem_we, imem_we, io_we} !== 12'h0) begin errors++; $display("FAIL reset_we: got %h want 000", {dmem_we, imem_we, io_we}); end
      checks++; if ({resp_data, resp_rd} !== 37'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", {resp_data, resp_rd}); end
      checks++; if ({w_req_ready, w_resp_valid, w_io_valid} !== 3'b0) begin errors++; $display("FAIL reset_w: got %b want 000", {w_req_ready, w_resp_valid, w_io_valid}); end
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1 || w_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b%b want 11", req_ready, w_req_ready); end
  endtask

  task automatic test_directed;
    @(negedge clk); drive_req(1, 1, 0, 0, 32'h1000_0001, 32'h1234_56AB, 0); #1;
    checks++; if (dmem_we !== 4'b0100 || imem_we !== 4'b0) begin errors++; $display("FAIL sb_we: got %b/%b want 0100/0000", dmem_we, imem_we); end
    checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab", dmem_wdata); end
    @(negedge clk); drive_req(1, 0, 0, 0, 32'h1000_0001, 0, 5); #1;
    @(negedge clk); drive_req(1, 0, 0, 1, 32'h1000_0001, 0, 6); dmem_rdata = 32'h00AB_0000; #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFAB || resp_rd !== 5'd5) begin errors++; $display("FAIL lb: got %b %h %0d want 1 ffffffab 5", resp_valid, resp_data, resp_rd); end
    @(negedge clk); drive_req(1, 1, 2, 0, 32'h3000_0008, 32'h1234_5678, 0); #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_00AB || resp_rd !== 5'd6) begin errors++; $display("FAIL lbu: got %b %h %0d want 1 000000ab 6", resp_valid, resp_data, resp_rd); end
    checks++; if (dmem_we !== 4'hF || imem_we !== 4'hF || dmem_addr !== 12'd2 || imem_addr !== 12'd2) begin errors++; $display("FAIL sw_both: got %b %b %0d %0d want 1111 1111 2 2", dmem_we, imem_we, dmem_addr, imem_addr); end
    checks++; if (imem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sw_imem_wdata: got %h want 12345678", imem_wdata); end
    @(negedge clk); drive_req(1, 0, 1, 0, 32'h1000_0003, 0, 4); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL store_no_resp: got %b want 0", resp_valid); end
    @(negedge clk); drive_req(1, 1, 3, 0, 32'h1000_0000, 32'hFFFF_FFFF, 0); #1;
    checks++; if (err_misalign !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lh_misalign: got err=%b resp=%b want 1 0", err_misalign, resp_valid); end
    checks++; if (dmem_we !== 4'b0 || imem_we !== 4'b0) begin errors++; $display("FAIL sd32_we: got %b %b want 0 0", dmem_we, imem_we); end
    @(negedge clk); drive_req(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (err_misalign !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL sd32_misalign: got err=%b resp=%b want 1 0", err_misalign, resp_valid); end
    @(negedge clk); #1;
    checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b want 0", err_misalign); end
  endtask

  task automatic test_random;
    bit p_ld = 0, p_mis = 0, p_dmem = 0, p_uns = 0;
    int p_sz = 0, p_off = 0;
    logic [4:0] p_rd = 0;
    for (int i = 0; i <= 300; i++) begin
      int sz, off;
      bit st, vld, uns, mis, mem, imem;
      logic [3:0] region, e_d, e_i;
      logic [31:0] tmp;
      @(negedge clk);
      vld = (i < 300) && ($urandom_range(0, 5) != 0);
      sz = $urandom_range(0, 3); off = $urandom_range(0, 3);
      st = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: region = 4'h1; 1: region = 4'h2; 2: region = 4'h3; 3: region = 4'h0; default: region = 4'hC;
      endcase
      tmp = $urandom;
      drive_req(vld, st, sz, uns, {region, tmp[27:2], 2'(off)}, $urandom, 5'($urandom_range(0, 31)));
      dmem_rdata = $urandom;
      #1;
      mis = m_misalign(sz, off);
      mem = (region == 4'h1) || (region == 4'h3);
      imem = (region == 4'h2) || (region == 4'h3);
      e_d = (vld && st && !mis && mem) ? m_lanes(sz, off) : 4'b0;
      e_i = (vld && st && !mis && imem) ? m_lanes(sz, off) : 4'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want 1", i, req_ready); end
      checks++; if (dmem_addr !== req_addr[13:2]) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, dmem_addr, req_addr[13:2]); end
      checks++; if (dmem_we !== e_d || imem_we !== e_i) begin errors++; $display("FAIL rnd_we[%0d]: got %b/%b want %b/%b", i, dmem_we, imem_we, e_d, e_i); end
      if (vld && st && !mis) begin
        checks++; if (dmem_wdata !== m_wdata(sz, req_wdata)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, dmem_wdata, m_wdata(sz, req_wdata)); end
      end
      checks++; if (resp_valid !== p_ld || err_misalign !== p_mis) begin errors++; $display("FAIL rnd_pulse[%0d]: got resp=%b err=%b want %b %b", i, resp_valid, err_misalign, p_ld, p_mis); end
      if (p_ld) begin
        checks++;
        if (resp_data !== (p_dmem ? m_load(dmem_rdata, p_sz, p_off, p_uns) : 32'h0) || resp_rd !== p_rd) begin
          errors++; $display("FAIL rnd_load[%0d]: got %h rd %0d want %h rd %0d", i, resp_data, resp_rd, p_dmem ? m_load(dmem_rdata, p_sz, p_off, p_uns) : 32'h0, p_rd);
        end
      end
      p_ld = vld && !st && !mis; p_mis = vld && mis; p_dmem = mem;
      p_sz = sz; p_off = off; p_uns = uns; p_rd = req_rd;
    end
  endtask

  task automatic test_io_load;
    int low_cnt = 0;
    @(negedge clk); drive_req(1, 0, 2, 0, 32'h8000_0000, 0, 7); io_ready = 0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL io_accept: got %b want 1", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); req_valid = 0; io_ready = (c == 4); io_rdata = 32'hDEAD_BEEF; #1;
      if (!req_ready) low_cnt++;
      checks++; if (io_valid !== 1'b1 || io_we !== 4'b0 || io_addr !== 32'h8000_0000) begin errors++; $display("FAIL io_hold[%0d]: got %b %b %h want 1 0000 80000000", c, io_valid, io_we, io_addr); end
    end
    @(negedge clk); io_ready = 0; #1;
    checks++; if (low_cnt != 4 || req_ready !== 1'b1) begin errors++; $display("FAIL io_stall: got %0d low, ready %b want 4 1", low_cnt, req_ready); end
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF || resp_rd !== 5'd7 || err_timeout !== 1'b0) begin errors++; $display("FAIL io_resp: got %b %h %0d to=%b want 1 deadbeef 7 0", resp_valid, resp_data, resp_rd, err_timeout); end
  endtask

  task automatic test_io_timeout;
    int vcnt = 0;
    bit done = 0;
    @(negedge clk); drive_req(1, 0, 0, 0, 32'h8000_0005, 0, 9); io_ready = 0; #1;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk); req_valid = 0; #1;
      if (io_valid) vcnt++;
      else begin
        done = 1;
        checks++; if (vcnt != 8) begin errors++; $display("FAIL to_cycles: got %0d want 8", vcnt); end
        checks++; if (err_timeout !== 1'b1 || resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || resp_rd !== 5'd9) begin errors++; $display("FAIL to_resp: got %b %b %h %0d want 1 1 ffffffff 9", err_timeout, resp_valid, resp_data, resp_rd); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b want 1", req_ready); end
        drive_req(1, 0, 2, 0, 32'h1000_0004, 0, 10);
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL to_bound: io_valid still %b after 20 cycles, want low", io_valid); end
    @(negedge clk); req_valid = 0; dmem_rdata = 32'h1122_3344; #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1122_3344 || err_timeout !== 1'b0) begin errors++; $display("FAIL to_next: got %b %h to=%b want 1 11223344 0", resp_valid, resp_data, err_timeout); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive_req(1, 0, 1, 0, 32'h1000_0002, 0, 3); #1;
    @(negedge clk); drive_req(1, 1, 0, 0, 32'h8000_0003, 32'h0000_005A, 0); dmem_rdata = 32'h0000_BEEF; #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_BEEF || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_resp: got %b %h rdy %b want 1 ffffbeef 1", resp_valid, resp_data, req_ready); end
    @(negedge clk); req_valid = 0; io_ready = 1; #1;
    checks++; if (io_valid !== 1'b1 || io_we !== 4'b0001 || io_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_io: got %b %b %h want 1 0001 5a5a5a5a", io_valid, io_we, io_wdata); end
    @(negedge clk); io_ready = 0; #1;
    checks++; if (io_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b %b %b want 0 0 1", io_valid, resp_valid, req_ready); end
  endtask

  task automatic test_rst_io;
    @(negedge clk); drive_req(1, 0, 2, 0, 32'h8000_0010, 0, 11); io_ready = 0; #1;
    @(negedge clk); req_valid = 0; rst = 1; #1;
    @(negedge clk); rst = 0; #1;
    checks++; if (io_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_io: got %b %b want 0 0", io_valid, resp_valid); end
    @(negedge clk); io_ready = 1; io_rdata = 32'h5555_5555; #1;
    @(negedge clk); io_ready = 0; #1;
    checks++; if (resp_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b %b want 0 0", resp_valid, err_timeout); end
  endtask

  task automatic test_dw64;
    @(negedge clk); w_req_valid = 1; w_req_store = 0; w_req_size = 3; w_req_unsigned = 0; w_req_addr = 32'h1000_0008; w_req_rd = 1; #1;
    checks++; if (w_dmem_addr !== 12'd1) begin errors++; $display("FAIL w_addr: got %0d want 1", w_dmem_addr); end
    @(negedge clk); w_req_size = 2; w_req_addr = 32'h1000_000C; w_req_rd = 2; w_dmem_rdata = 64'h0102_0304_0506_0708; #1;
    checks++; if (w_resp_valid !== 1'b1 || w_resp_data !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL w_ld: got %b %h want 1 0102030405060708", w_resp_valid, w_resp_data); end
    @(negedge clk); w_req_size = 0; w_req_addr = 32'h1000_0007; w_req_rd = 3; #1;
    checks++; if (w_resp_data !== 64'h0000_0000_0506_0708 || w_resp_rd !== 5'd2) begin errors++; $display("FAIL w_lw4: got %h rd %0d want 05060708 rd 2", w_resp_data, w_resp_rd); end
    @(negedge clk); w_req_store = 1; w_req_size = 1; w_req_addr = 32'h1000_0006; w_req_wdata = 64'hFFFF_FFFF_FFFF_C3D4; w_dmem_rdata = 64'h0000_0000_0000_0088; #1;
    checks++; if (w_resp_data !== 64'hFFFF_FFFF_FFFF_FF88) begin errors++; $display("FAIL w_lb7: got %h want ffffffffffffff88", w_resp_data); end
    checks++; if (w_dmem_we !== 8'b0000_0011 || w_dmem_wdata !== 64'hC3D4_C3D4_C3D4_C3D4) begin errors++; $display("FAIL w_sh6: got %b %h want 00000011 c3d4c3d4c3d4c3d4", w_dmem_we, w_dmem_wdata); end
    @(negedge clk); w_req_store = 0; w_req_size = 3; w_req_addr = 32'h1000_0004; #1;
    @(negedge clk); w_req_valid = 0; #1;
    checks++; if (w_err_misalign !== 1'b1 || w_resp_valid !== 1'b0) begin errors++; $display("FAIL w_ld_mis: got %b %b want 1 0", w_err_misalign, w_resp_valid); end
  endtask

  initial begin
    drive_req(0, 0, 0, 0, 0, 0, 0);
    dmem_rdata = 0; io_ready = 0; io_rdata = 0;
    w_req_valid = 0; w_req_store = 0; w_req_size = 0; w_req_unsigned = 0; w_req_addr = 0;
    w_req_wdata = 0; w_req_rd = 0; w_dmem_rdata = 0; w_io_ready = 0; w_io_rdata = 0;
    test_reset();
    test_directed();
    test_random();
    test_io_load();
    test_io_timeout();
    test_back_to_back();
    test_rst_io();
    test_dw64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
